// File: rtl/ram_pkg.sv
// Shared types and default geometry for the parametrised data RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_pkg;

    // Default geometry matches the legacy 16-bit x 16K data memory used by the CPU top.
    localparam int RAM_WIDTH_DEF  = 16;
    localparam int RAM_ADDR_W_DEF = 14;

    // Controller states: sweeping zeros through the array, or serving requests.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // State entered on reset; skipping the sweep lets simulation-only builds start immediately.
    function automatic state_e reset_state(input bit clear_on_reset);
        return clear_on_reset ? ST_CLEAR : ST_READY;
    endfunction

endpackage

// File: rtl/ram_core.sv
// Plain single-port synchronous array, write and read share one address.
// Latency: read data registered, valid one cycle after the address is presented.
// Backpressure: none; every cycle performs a read and an optional write.
module ram_core
    import ram_pkg::*;
#(
    parameter int WIDTH  = RAM_WIDTH_DEF,
    parameter int ADDR_W = RAM_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Array content is deliberately not reset so it maps onto block RAM.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read-first port: rdata reflects the word before any same-edge write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/ram_param_init.sv
// Parametrised data RAM with valid/ready requests and a zero-fill clear engine.
// Latency: writes commit at the accept edge; read data returns one cycle after accept.
// Backpressure: req_ready low while clearing or when a clear is requested; responses have none.
module ram_param_init
    import ram_pkg::*;
#(
    parameter int WIDTH          = RAM_WIDTH_DEF,
    parameter int ADDR_W         = RAM_ADDR_W_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    input  logic              clear_req,
    output logic              busy
);

    // The counter naturally wraps to zero after the last word, so no explicit wrap logic is needed.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_hold_q;

    logic              accept;
    logic              rd_accept;
    logic              wr_accept;

    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [WIDTH-1:0]  core_wdata;
    logic [WIDTH-1:0]  core_rdata;

    // A pending clear takes priority over any request presented in the same cycle.
    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = (state_q == ST_READY) && !clear_req;
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign wr_accept = accept && req_we;

    // Array port mux: the sweep owns the port while clearing, otherwise the requester does.
    always_comb begin
        core_we    = wr_accept;
        core_addr  = req_addr;
        core_wdata = req_wdata;
        if (busy) begin
            core_we    = 1'b1;
            core_addr  = cnt_q;
            core_wdata = '0;
        end
    end

    // Next-state logic for the clear sweep and the return to request service.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = reset_state(CLEAR_ON_RESET);
                cnt_d   = '0;
            end
        endcase
    end

    // One response pulse per accepted read, issued the cycle after acceptance.
    assign rsp_valid_d = rd_accept;

    // Controller state, sweep counter and response strobe; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= reset_state(CLEAR_ON_RESET);
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Remember the last delivered word so rsp_data stays stable between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_hold_q <= '0;
        end else if (rsp_valid_q) begin
            rsp_hold_q <= core_rdata;
        end
    end

    // Array read data is only meaningful in the response cycle; otherwise show the held word.
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_valid_q ? core_rdata : rsp_hold_q;

    ram_core #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

endmodule

// File: tb/tb_ram_param_init.sv
// Bench for ram_param_init: small-array instance against a behavioural model, large-array no-clear instance directed.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_param_init;

    localparam int W    = 16;
    localparam int AW_A = 4;
    localparam int DEP_A = 16;
    localparam int AW_B = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 16-word array, clear on reset
    logic            a_rst_n = 1'b1;
    logic            a_req_valid = 1'b0;
    logic            a_req_we = 1'b0;
    logic [AW_A-1:0] a_req_addr = '0;
    logic [W-1:0]    a_req_wdata = '0;
    logic            a_clear_req = 1'b0;
    logic            a_req_ready, a_rsp_valid, a_busy;
    logic [W-1:0]    a_rsp_data;

    // Instance B: 16K-word array, no clear on reset
    logic            b_rst_n = 1'b1;
    logic            b_req_valid = 1'b0;
    logic            b_req_we = 1'b0;
    logic [AW_B-1:0] b_req_addr = '0;
    logic [W-1:0]    b_req_wdata = '0;
    logic            b_clear_req = 1'b0;
    logic            b_req_ready, b_rsp_valid, b_busy;
    logic [W-1:0]    b_rsp_data;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    ram_param_init #(.WIDTH(W), .ADDR_W(AW_A), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .clear_req(a_clear_req), .busy(a_busy)
    );

    ram_param_init #(.WIDTH(W), .ADDR_W(AW_B), .CLEAR_ON_RESET(1'b0)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .clear_req(b_clear_req), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model of instance A ----------------
    // m_left = number of sweep cycles still to run (0 means serving requests).
    int           m_left = DEP_A;
    logic [W-1:0] m_mem [DEP_A];
    logic         m_rv = 1'b0;
    logic [W-1:0] m_rd = '0;

    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            m_left = DEP_A;
            m_rv   = 1'b0;
            m_rd   = '0;
        end else if (m_left > 0) begin
            m_mem[DEP_A - m_left] = '0;
            m_left = m_left - 1;
            m_rv   = 1'b0;
        end else begin
            m_rv = 1'b0;
            if (a_clear_req) begin
                m_left = DEP_A;
            end else if (a_req_valid) begin
                if (a_req_we) begin
                    m_mem[a_req_addr] = a_req_wdata;
                end else begin
                    m_rv = 1'b1;
                    m_rd = m_mem[a_req_addr];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_busy",      {31'd0, a_busy},      {31'd0, m_left != 0});
            chk("cmp_req_ready", {31'd0, a_req_ready}, {31'd0, (m_left == 0) && !a_clear_req});
            chk("cmp_rsp_valid", {31'd0, a_rsp_valid}, {31'd0, m_rv});
            chk("cmp_rsp_data",  {16'd0, a_rsp_data},  {16'd0, m_rd});
        end
    end

    // ---------------- directed helpers for instance A ----------------
    task automatic a_idle();
        a_req_valid = 1'b0;
        a_req_we    = 1'b0;
        a_clear_req = 1'b0;
    endtask

    task automatic a_write(input logic [AW_A-1:0] ad, input logic [W-1:0] d);
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = ad;
        a_req_wdata = d;
        #1;
        chk("a_wr_ready", {31'd0, a_req_ready}, 32'd1);
        step();
        a_idle();
    endtask

    task automatic a_read(input string nm, input logic [AW_A-1:0] ad, input logic [W-1:0] exp);
        a_req_valid = 1'b1;
        a_req_we    = 1'b0;
        a_req_addr  = ad;
        step();
        a_idle();
        chk({nm, "_vld"}, {31'd0, a_rsp_valid}, 32'd1);
        chk({nm, "_dat"}, {16'd0, a_rsp_data}, {16'd0, exp});
    endtask

    task automatic a_count_busy(output int n, output bit saw_rsp, output bit saw_rdy);
        n = 0;
        saw_rsp = 1'b0;
        saw_rdy = 1'b0;
        while (a_busy && n < 200) begin
            if (a_rsp_valid) saw_rsp = 1'b1;
            if (a_req_ready) saw_rdy = 1'b1;
            n++;
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_rsp, saw_rdy;
        logic [W-1:0] t3 [3];
        logic [AW_A-1:0] a3 [3];

        // Reset both instances
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        chk_en  = 1'b1;
        #1;
        chk("rst_busy",      {31'd0, a_busy},      32'd1);
        chk("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {16'd0, a_rsp_data},  32'd0);
        step();
        step();

        // Test 1: clear after reset lasts exactly 16 cycles, then all words read zero
        a_rst_n = 1'b1;
        a_count_busy(n, saw_rsp, saw_rdy);
        chk("t1_busy_cycles", n, 32'd16);
        chk("t1_ready_during_clear", {31'd0, saw_rdy}, 32'd0);
        for (int i = 0; i < DEP_A; i++) begin
            a_read("t1_zero", AW_A'(i), 16'h0000);
        end

        // Test 3: streaming writes then back-to-back reads
        a_write(4'd1, 16'h1111);
        a_write(4'd2, 16'h2222);
        a_write(4'd3, 16'h3333);
        a3[0] = 4'd3; t3[0] = 16'h3333;
        a3[1] = 4'd1; t3[1] = 16'h1111;
        a3[2] = 4'd2; t3[2] = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            a_read("t3_stream", a3[i], t3[i]);
        end
        step();

        // Test 4: clear wins over a simultaneous write; prior read still answered
        a_req_valid = 1'b1;
        a_req_we    = 1'b0;
        a_req_addr  = 4'd1;
        step();
        a_clear_req = 1'b1;
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = 4'd5;
        a_req_wdata = 16'hBEEF;
        #1;
        chk("t4_ready_low",  {31'd0, a_req_ready}, 32'd0);
        chk("t4_busy_low",   {31'd0, a_busy},      32'd0);
        chk("t4_last_rsp_v", {31'd0, a_rsp_valid}, 32'd1);
        chk("t4_last_rsp_d", {16'd0, a_rsp_data},  32'h1111);
        step();
        a_idle();
        chk("t4_busy_rise", {31'd0, a_busy}, 32'd1);
        a_count_busy(n, saw_rsp, saw_rdy);
        chk("t4_busy_cycles", n, 32'd16);
        a_read("t4_addr5", 4'd5, 16'h0000);
        a_read("t4_addr3", 4'd3, 16'h0000);

        // Test 5: reset in the middle of a clear restarts the full sweep
        a_write(4'd7, 16'h7777);
        a_req_valid = 1'b1;
        a_req_we    = 1'b0;
        a_req_addr  = 4'd7;
        step();
        a_idle();
        a_rst_n = 1'b0;
        #1;
        chk("t5_rst_drop_rsp", {31'd0, a_rsp_valid}, 32'd0);
        chk("t5_rst_data",     {16'd0, a_rsp_data},  32'd0);
        step();
        a_rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step();
        a_rst_n = 1'b0;
        step();
        a_rst_n = 1'b1;
        a_count_busy(n, saw_rsp, saw_rdy);
        chk("t5_busy_cycles", n, 32'd16);
        chk("t5_no_rsp",      {31'd0, saw_rsp}, 32'd0);
        a_read("t5_addr7", 4'd7, 16'h0000);

        // Randomised traffic on instance A, checked every cycle by the model
        for (int c = 0; c < 800; c++) begin
            a_req_valid = ($urandom_range(0, 3) != 0);
            a_req_we    = 1'($urandom_range(0, 1));
            a_req_addr  = AW_A'($urandom_range(0, DEP_A - 1));
            a_req_wdata = 16'($urandom);
            a_clear_req = ($urandom_range(0, 59) == 0);
            step();
        end
        a_idle();
        step();
        step();

        // Tests 2 and 6 on the 16K instance without clear-on-reset
        b_rst_n = 1'b1;
        #1;
        chk("t6_ready_first", {31'd0, b_req_ready}, 32'd1);
        chk("t6_busy",        {31'd0, b_busy},      32'd0);
        chk("t6_rsp_valid",   {31'd0, b_rsp_valid}, 32'd0);
        chk("t6_rsp_data",    {16'd0, b_rsp_data},  32'd0);
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = 14'h002A;
        b_req_wdata = 16'hF00D;
        step();
        b_req_we    = 1'b0;
        step();
        b_req_valid = 1'b0;
        chk("t2_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
        chk("t2_rsp_data",  {16'd0, b_rsp_data},  32'hF00D);
        step();
        chk("t2_pulse_once", {31'd0, b_rsp_valid}, 32'd0);
        step();
        chk("t2_hold_valid", {31'd0, b_rsp_valid}, 32'd0);
        chk("t2_hold_data",  {16'd0, b_rsp_data},  32'hF00D);
        b_req_valid = 1'b1;
        b_req_we    = 1'b1;
        b_req_addr  = 14'h3FFF;
        b_req_wdata = 16'h00A5;
        step();
        b_req_we    = 1'b0;
        step();
        b_req_valid = 1'b0;
        chk("t6_rt_valid", {31'd0, b_rsp_valid}, 32'd1);
        chk("t6_rt_data",  {16'd0, b_rsp_data},  32'h00A5);
        step();
        chk("t6_busy_end", {31'd0, b_busy}, 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
